// File: rtl/mode_select_pkg.sv
// Shared types and helpers for mode_select_ctrl: audio trigger FSM states and
// modular step functions for the mode index (indices fit in 6 bits, up to 64 modes).
package mode_select_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    HOLDOFF = 2'd1,
    REARM   = 2'd2
  } audio_st_e;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input int n);
    return (int'(v) >= n - 1) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input int n);
    return (v == 6'd0) ? 6'(n - 1) : v - 6'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-FF synchroniser -> debounced stable level -> one-cycle
// press pulse on the stable level's high-to-low edge.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // With only two levels, any sample equal to the stable state is a change back,
  // so clearing the counter there is the same as restarting on any change.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
        press_d  = stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/mode_select_ctrl.sv
// Mode selector: debounced next/prev keys step a wrapping mode index; with
// MODE_SELECT_AUDIO_TRIG_EN defined, a loud audio level also advances it.
module mode_select_ctrl
  import mode_select_pkg::*;
#(
  parameter int NUM_MODES    = 4,
  parameter int LED_W        = 18,
  parameter int LEVEL_W      = 10,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int HOLDOFF_CYC  = 25000000
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         key_next_n,
  input  logic                         key_prev_n,
  input  logic [LEVEL_W-1:0]           level,
  input  logic [LEVEL_W-1:0]           level_thresh,
  input  logic                         auto_en,
  output logic [$clog2(NUM_MODES)-1:0] curr_select,
  output logic [LED_W-1:0]             LEDR,
  output logic                         mode_changed
);

  localparam int SEL_W = $clog2(NUM_MODES);

  logic             nxt_ev, prv_ev, trig;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             mc_q, mc_d;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_next (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .key_n_i (key_next_n),
    .press_o (nxt_ev)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_prev (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .key_n_i (key_prev_n),
    .press_o (prv_ev)
  );

`ifdef MODE_SELECT_AUDIO_TRIG_EN
  localparam int HCNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC + 1) : 1;

  audio_st_e         state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  assign trig = (state_q == ARMED) && auto_en && (level >= level_thresh);

  // A trigger that lands on a key event is dropped, so the FSM stays ARMED.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    if (!auto_en) begin
      state_d = ARMED;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ARMED: if (trig && !nxt_ev && !prv_ev) begin
          state_d = HOLDOFF;
          hcnt_d  = HCNT_W'(HOLDOFF_CYC - 1);
        end
        HOLDOFF: if (hcnt_q == '0) state_d = REARM;
                 else              hcnt_d  = hcnt_q - 1'b1;
        REARM:   if (level < level_thresh) state_d = ARMED;
        default: begin
          state_d = ARMED;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ARMED;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end
`else
  logic unused_audio;
  assign unused_audio = ^{level, level_thresh, auto_en};
  assign trig = 1'b0;
`endif

  always_comb begin
    sel_d = sel_q;
    if (nxt_ev && !prv_ev)
      sel_d = SEL_W'(wrap_inc(6'(sel_q), NUM_MODES));
    else if (prv_ev && !nxt_ev)
      sel_d = SEL_W'(wrap_dec(6'(sel_q), NUM_MODES));
    else if (!nxt_ev && !prv_ev && trig)
      sel_d = SEL_W'(wrap_inc(6'(sel_q), NUM_MODES));
  end

  // LEDR is decoded from the next index so it lines up with curr_select.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < LED_W; i++) led_d[i] = (int'(sel_d) == i);
    mc_d = (sel_d != sel_q);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
      led_q <= LED_W'(1);
      mc_q  <= 1'b0;
    end else begin
      sel_q <= sel_d;
      led_q <= led_d;
      mc_q  <= mc_d;
    end
  end

  assign curr_select  = sel_q;
  assign LEDR         = led_q;
  assign mode_changed = mc_q;

endmodule

// File: doc/mode_select_ctrl.md
MODE_SELECT_CTRL -- requirements
Module: mode_select_ctrl

Interface
REQ-001 SHALL have parameter NUM_MODES, 4, number of selectable processing modes (2..64).
REQ-002 SHALL have parameter LED_W, 18, width of LED output bus.
REQ-003 SHALL have parameter LEVEL_W, 10, width of audio level input.
REQ-004 SHALL have parameter DEBOUNCE_CYC, 500000, cycles a key must be stable before it is accepted.
REQ-005 SHALL have parameter HOLDOFF_CYC, 25000000, minimum cycles between audio-triggered advances.
REQ-006 SHALL have port CLOCK_50  input  1  sole clock; all state on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port key_next_n  input  1  raw active-low push-button, advance mode.
REQ-009 SHALL have port key_prev_n  input  1  raw active-low push-button, retreat mode.
REQ-010 SHALL have port level  input  LEVEL_W  unsigned audio magnitude from the microphone path.
REQ-011 SHALL have port level_thresh  input  LEVEL_W  audio trigger threshold.
REQ-012 SHALL have port auto_en  input  1  enables audio-triggered advance.
REQ-013 SHALL have port curr_select  output  $clog2(NUM_MODES)  current mode index.
REQ-014 SHALL have port LEDR  output  LED_W  one-hot mode indicator.
REQ-015 SHALL have port mode_changed  output  1  one-cycle pulse the cycle curr_select takes a new value.

Function
REQ-016 Each key SHALL pass a 2-FF synchroniser, then a debouncer updating its stable state only after DEBOUNCE_CYC consecutive equal samples; counter restarts on any change.
REQ-017 A press event SHALL be a one-cycle pulse on the stable state's high-to-low transition; release produces no event.
REQ-018 curr_select SHALL update one cycle after an accepted event (registered); next: +1 wrapping NUM_MODES-1 -> 0; prev: -1 wrapping 0 -> NUM_MODES-1.
REQ-019 Priority per cycle: next and prev together -> no change, neither consumed as audio override; else next > prev > audio trigger.
REQ-020 Audio FSM states ARMED, HOLDOFF, REARM: ARMED & auto_en & level >= level_thresh (unsigned) -> advance, HOLDOFF, load counter; HOLDOFF counts HOLDOFF_CYC cycles -> REARM; REARM & level < level_thresh -> ARMED.
REQ-021 An audio trigger coinciding with a key event SHALL be discarded; FSM remains ARMED.
REQ-022 auto_en low SHALL force FSM to ARMED next cycle with counter cleared; no advance.
REQ-023 LEDR SHALL be the registered decode of curr_select: bit curr_select set, others zero; modes >= LED_W drive LEDR all zero.
REQ-024 mode_changed SHALL assert exactly when curr_select's registered value differs from the prior cycle.

Reset
REQ-025 On reset: curr_select=0, LEDR=1 (bit 0 only), mode_changed=0, FSM=ARMED, counters 0, debounced key states released (high).
REQ-026 Reset asserted mid-debounce or mid-holdoff SHALL abandon the operation; no event is generated after release.

Configuration
REQ-027 Macro MODE_SELECT_AUDIO_TRIG_EN defined: audio FSM, level, level_thresh, auto_en functional per REQ-020..022.
REQ-028 Macro undefined: FSM and holdoff counter not built; level, level_thresh, auto_en ports remain but are ignored; only keys change mode.

Structure
REQ-029 Package mode_select_pkg SHALL hold the audio FSM state enum and the wrap-increment/decrement helper functions.
REQ-030 One sub-module key_debounce (synchroniser, debounce counter, press pulse) SHALL be instantiated once per key.

Verification (NUM_MODES=5, LED_W=4, DEBOUNCE_CYC=4, HOLDOFF_CYC=8)
REQ-031 Reset, hold key_next_n low 10 cycles -> one mode_changed pulse, curr_select 0->1, LEDR 4'b0010, event 2+4+1 cycles after press.
REQ-032 From mode 0 press prev -> curr_select=4, LEDR=4'b0000; press next -> curr_select=0, LEDR=4'b0001.
REQ-033 key_next_n glitching low 3 cycles then high -> no event, curr_select unchanged.
REQ-034 auto_en=1, thresh=100, level held 200 for 30 cycles -> exactly one advance; drop level to 50 then 200 again -> second advance.
REQ-035 Both keys accepted same cycle -> no change, no pulse; key event with audio trigger same cycle -> single advance, FSM stays ARMED.
REQ-036 Reset asserted during HOLDOFF -> curr_select=0, LEDR=1, FSM ARMED; macro undefined -> level stimulus of REQ-034 causes no change.
